pulse_hs_mc: RTL

PULSE_HS_MC -- requirements
Module: pulse_hs_mc

---
 rtl/pulse_hs_pkg.sv | 14 +
 rtl/pulse_hs_mc_sync_chain.sv | 24 ++
 rtl/pulse_hs_mc.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/pulse_hs_pkg.sv
// Shared types for the multi-channel pulse handshake block.
// FSM state encoding and handshake protocol selectors.
package pulse_hs_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    localparam int MODE_FOUR_PHASE = 0;
    localparam int MODE_TWO_PHASE  = 1;

endpackage

// File: rtl/pulse_hs_mc_sync_chain.sv
// Multi-flop synchroniser for a single asynchronous level.
// All stages clear to 0 on synchronous reset.
module sync_chain #(
    parameter int STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else begin
            r_q <= {r_q[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_q[STAGES-1];

endmodule

// File: rtl/pulse_hs_mc.sv
// Per-channel pulse counters feeding a round-robin arbiter and
// a four-phase or two-phase request/acknowledge handshake.
module pulse_hs_mc
    import pulse_hs_pkg::*;
#(
    parameter int CH          = 4,
    parameter int CNT_W       = 3,
    parameter int SYNC_STAGES = 2,
    parameter int MODE        = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [CH-1:0]           pulse_in,
    input  logic                    ack_in,
    input  logic [CH-1:0]           ovf_clr,
    output logic                    req_out,
    output logic [$clog2(CH)-1:0]   ch_id,
    output logic                    busy,
    output logic                    done,
    output logic [CH*CNT_W-1:0]     pend_cnt,
    output logic [CH-1:0]           overflow
);

    localparam int ID_W = $clog2(CH);
    localparam int J_W  = ID_W + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t          r_state;
    logic            r_req;
    logic            r_done;
    logic [ID_W-1:0] r_ch;
    logic [ID_W-1:0] r_last;

    logic            w_ack_s;
    logic [CH-1:0]   w_nz;
    logic            w_found;
    logic            w_grant;
    logic [ID_W-1:0] w_gnt_idx;
    logic [J_W-1:0]  w_j;

    sync_chain #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_d     (ack_in),
        .o_q     (w_ack_s)
    );

    // Search starts one past the last granted channel and wraps.
    always_comb begin
        w_found   = 1'b0;
        w_gnt_idx = '0;
        w_j       = '0;
        for (int k = 1; k <= CH; k++) begin
            w_j = {1'b0, r_last} + J_W'(k);
            if (w_j >= J_W'(CH)) begin
                w_j = w_j - J_W'(CH);
            end
            if (!w_found && w_nz[w_j[ID_W-1:0]]) begin
                w_found   = 1'b1;
                w_gnt_idx = w_j[ID_W-1:0];
            end
        end
    end

    assign w_grant = (r_state == ST_IDLE) && w_found;

    for (genvar g = 0; g < CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_cnt;
        logic             r_ovf;
        logic             w_inc;
        logic             w_dec;
        logic             w_sat;

        assign w_inc = pulse_in[g];
        assign w_dec = w_grant && (w_gnt_idx == ID_W'(g));
        assign w_sat = (r_cnt == CNT_MAX);

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_cnt <= '0;
                r_ovf <= 1'b0;
            end else begin
                if (w_inc && !w_dec) begin
                    if (!w_sat) begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end else if (w_dec && !w_inc) begin
                    r_cnt <= r_cnt - 1'b1;
                end
                // A lost event outranks a same-cycle clear.
                if (w_inc && !w_dec && w_sat) begin
                    r_ovf <= 1'b1;
                end else if (ovf_clr[g]) begin
                    r_ovf <= 1'b0;
                end
            end
        end

        assign pend_cnt[g*CNT_W +: CNT_W] = r_cnt;
        assign overflow[g]                = r_ovf;
        assign w_nz[g]                    = |r_cnt;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_done  <= 1'b0;
            r_ch    <= '0;
            r_last  <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_ch    <= w_gnt_idx;
                        r_last  <= w_gnt_idx;
                        r_state <= ST_REQ;
                        r_req   <= (MODE == MODE_TWO_PHASE) ? ~r_req : 1'b1;
                    end
                end
                ST_REQ: begin
                    if (MODE == MODE_TWO_PHASE) begin
                        if (w_ack_s == r_req) begin
                            r_done  <= 1'b1;
                            r_state <= ST_IDLE;
                        end
                    end else if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= ST_REL;
                    end
                end
                ST_REL: begin
                    if (!w_ack_s) begin
                        r_done  <= 1'b1;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign req_out = r_req;
    assign ch_id   = r_ch;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule
